// File: rtl/render_arb_pkg.sv
// Shared constants, FSM state type and one-hot legality check for the render
// request tracker and its grant decoder.
package render_arb_pkg;

   localparam int N_CLIENTS = 6;
   localparam int IDX_W     = 3;
   localparam int BURST_LEN = 4;
   localparam int BEAT_W    = 2;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic logic is_onehot(input logic [N_CLIENTS-1:0] v);
      return (v != '0) && ((v & (v - N_CLIENTS'(1))) == '0);
   endfunction

endpackage

// File: rtl/render_onehot_enc.sv
// Combinational one-hot to index encoder; onehot_ok flags exactly one bit set
// so the caller can reject empty or multi-bit grants.
module render_onehot_enc
   import render_arb_pkg::*;
(
   input  logic [N_CLIENTS-1:0] onehot,
   output logic [IDX_W-1:0]     idx,
   output logic                 onehot_ok
);

   always_comb begin
      // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
      idx = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (onehot[i]) idx = idx | IDX_W'(i);
      end
   end

   assign onehot_ok = is_onehot(onehot);

endmodule

// File: rtl/render_req_tracker.sv
// Collects client request pulses into a pending vector, runs one fixed-length
// burst per arbiter grant and pulses done on retirement.
// Build option: RENDER_TRACKER_REQ_COUNT_EN gives each client a saturating request counter.
module render_req_tracker
   import render_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CLIENTS-1:0] req_pulse,
   output logic [N_CLIENTS-1:0] req_vec,
   input  logic [N_CLIENTS-1:0] gnt_onehot,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic [IDX_W-1:0]     bus_client,
   output logic [BEAT_W-1:0]    bus_beat,
   output logic                 bus_last,
   output logic [N_CLIENTS-1:0] done,
   output logic                 err_gnt
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   state_e                 state_q;
   logic [N_CLIENTS-1:0]   grant_q;
   logic [IDX_W-1:0]       idx_q;
   logic [BEAT_W-1:0]      beat_q;
   logic                   valid_q;
   logic [N_CLIENTS-1:0]   done_q;
   logic                   err_q;

   logic [IDX_W-1:0]       gnt_idx;
   logic                   gnt_ok;
   logic                   gnt_legal;
   logic                   retire;
   logic [N_CLIENTS-1:0]   retire_vec;

   render_onehot_enc u_enc (
      .onehot    (gnt_onehot),
      .idx       (gnt_idx),
      .onehot_ok (gnt_ok)
   );

   assign gnt_legal  = gnt_ok && ((gnt_onehot & req_vec) != '0);
   assign bus_last   = (state_q == BURST) && (beat_q == LAST_BEAT);
   assign retire     = bus_last && bus_ready;
   assign retire_vec = retire ? grant_q : '0;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         beat_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         done_q <= '0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_onehot != '0) begin
                  if (gnt_legal) begin
                     grant_q <= gnt_onehot;
                     idx_q   <= gnt_idx;
                     beat_q  <= '0;
                     valid_q <= 1'b1;
                     state_q <= BURST;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            BURST: begin
               if (bus_ready) begin
                  if (bus_last) begin
                     beat_q  <= '0;
                     valid_q <= 1'b0;
                     done_q  <= grant_q;
                     state_q <= DONE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef RENDER_TRACKER_REQ_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] cnt_q [N_CLIENTS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the counter array is reset because req_vec is decoded straight from it.
         for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            case ({req_pulse[i], retire_vec[i]})
               2'b10:   if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
               2'b01:   if (cnt_q[i] != '0)      cnt_q[i] <= cnt_q[i] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_CLIENTS; i++) req_vec[i] = (cnt_q[i] != '0);
   end
`else
   logic [N_CLIENTS-1:0] pending_q;

   // A new pulse overrides a same-cycle retirement so the client is served again.
   always_ff @(posedge clk) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= (pending_q & ~retire_vec) | req_pulse;
   end

   assign req_vec = pending_q;
`endif

   assign bus_valid  = valid_q;
   assign bus_client = idx_q;
   assign bus_beat   = beat_q;
   assign done       = done_q;
   assign err_gnt    = err_q;

endmodule

// File: tb/tb_render_req_tracker.sv
// Directed bench for render_req_tracker; models the MSB-priority arbiter and
// checks hand-computed cycle-exact outputs.
module tb_render_req_tracker;
   import render_arb_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_CLIENTS-1:0] req_pulse;
   logic [N_CLIENTS-1:0] req_vec;
   logic [N_CLIENTS-1:0] gnt_onehot;
   logic                 bus_valid;
   logic                 bus_ready;
   logic [IDX_W-1:0]     bus_client;
   logic [BEAT_W-1:0]    bus_beat;
   logic                 bus_last;
   logic [N_CLIENTS-1:0] done;
   logic                 err_gnt;

   logic                 force_en;
   logic [N_CLIENTS-1:0] force_gnt;

   int checks   = 0;
   int failures = 0;

   render_req_tracker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_pulse  (req_pulse),
      .req_vec    (req_vec),
      .gnt_onehot (gnt_onehot),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .bus_client (bus_client),
      .bus_beat   (bus_beat),
      .bus_last   (bus_last),
      .done       (done),
      .err_gnt    (err_gnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      gnt_onehot = '0;
      if (force_en) begin
         gnt_onehot = force_gnt;
      end else begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            if (req_vec[i]) gnt_onehot = N_CLIENTS'(1) << i;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [N_CLIENTS-1:0] v);
      req_pulse = v;
      step();
      req_pulse = '0;
   endtask

   task automatic check_beat(input string tag, input int client, input int beat, input logic last);
      check({tag, "_valid"}, 32'(bus_valid), 32'd1);
      check({tag, "_client"}, 32'(bus_client), 32'(client));
      check({tag, "_beat"}, 32'(bus_beat), 32'(beat));
      check({tag, "_last"}, 32'(bus_last), 32'(last));
   endtask

   int done_cnt;
   int stray_done;

   initial begin
      rst_n     = 1'b0;
      req_pulse = '0;
      bus_ready = 1'b1;
      force_en  = 1'b0;
      force_gnt = '0;
      step();
      step();
      check("rst_req_vec", 32'(req_vec), 32'd0);
      check("rst_valid", 32'(bus_valid), 32'd0);
      check("rst_client", 32'(bus_client), 32'd0);
      check("rst_beat", 32'(bus_beat), 32'd0);
      check("rst_last", 32'(bus_last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_gnt), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic burst for client 2
      pulse(6'b000100);
      check("t1_req_vec", 32'(req_vec), 32'h04);
      check("t1_valid", 32'(bus_valid), 32'd0);
      step();
      check_beat("t2_b0", 2, 0, 1'b0);
      step();
      check_beat("t3_b1", 2, 1, 1'b0);
      step();
      check_beat("t4_b2", 2, 2, 1'b0);
      step();
      check_beat("t5_b3", 2, 3, 1'b1);
      step();
      check("t6_done", 32'(done), 32'h04);
      check("t6_req_vec", 32'(req_vec), 32'd0);
      check("t6_valid", 32'(bus_valid), 32'd0);
      step();
      check("t7_done", 32'(done), 32'd0);

      // Backpressure on beat 1 for three cycles, client 1
      pulse(6'b000010);
      step();
      check_beat("bp_b0", 1, 0, 1'b0);
      step();
      check_beat("bp_b1", 1, 1, 1'b0);
      bus_ready = 1'b0;
      step();
      check_beat("bp_hold1", 1, 1, 1'b0);
      step();
      check_beat("bp_hold2", 1, 1, 1'b0);
      step();
      check_beat("bp_hold3", 1, 1, 1'b0);
      check("bp_no_done", 32'(done), 32'd0);
      bus_ready = 1'b1;
      step();
      check_beat("bp_b2", 1, 2, 1'b0);
      step();
      check_beat("bp_b3", 1, 3, 1'b1);
      step();
      check("bp_done", 32'(done), 32'h02);
      step();

      // Illegal grants in IDLE: multi-bit, then non-pending single bit
      force_en  = 1'b1;
      force_gnt = 6'b101000;
      step();
      force_en = 1'b0;
      check("ill_multi_err", 32'(err_gnt), 32'd1);
      check("ill_multi_valid", 32'(bus_valid), 32'd0);
      step();
      check("ill_multi_err_clr", 32'(err_gnt), 32'd0);
      check("ill_multi_valid2", 32'(bus_valid), 32'd0);
      force_en  = 1'b1;
      force_gnt = 6'b000001;
      step();
      force_en = 1'b0;
      check("ill_np_err", 32'(err_gnt), 32'd1);
      check("ill_np_valid", 32'(bus_valid), 32'd0);
      step();
      check("ill_np_valid2", 32'(bus_valid), 32'd0);
      check("ill_np_err_clr", 32'(err_gnt), 32'd0);

      // Client 5 re-requests on its own last beat
      pulse(6'b100000);
      step();
      check_beat("rr_b0", 5, 0, 1'b0);
      step();
      step();
      step();
      check_beat("rr_b3", 5, 3, 1'b1);
      pulse(6'b100000);
      check("rr_done", 32'(done), 32'h20);
      check("rr_req_vec", 32'(req_vec), 32'h20);
      step();
      step();
      check_beat("rr2_b0", 5, 0, 1'b0);
      step();
      step();
      step();
      step();
      check("rr2_done", 32'(done), 32'h20);
      check("rr2_req_vec", 32'(req_vec), 32'd0);
      step();

      // Reset during beat 2 of client 4
      pulse(6'b010000);
      step();
      step();
      step();
      check_beat("mr_b2", 4, 2, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mr_valid", 32'(bus_valid), 32'd0);
      check("mr_req_vec", 32'(req_vec), 32'd0);
      check("mr_beat", 32'(bus_beat), 32'd0);
      stray_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done != '0) stray_done++;
         step();
      end
      check("mr_no_done", 32'(stray_done), 32'd0);

      // Three back-to-back pulses from client 0
      done_cnt = 0;
      req_pulse = 6'b000001;
      step();
      step();
      step();
      req_pulse = '0;
      for (int i = 0; i < 30; i++) begin
         if (done[0]) done_cnt++;
         step();
      end
`ifdef RENDER_TRACKER_REQ_COUNT_EN
      check("cnt_done_pulses", 32'(done_cnt), 32'd3);
`else
      check("cnt_done_pulses", 32'(done_cnt), 32'd1);
`endif
      check("cnt_req_vec", 32'(req_vec), 32'd0);
      check("cnt_valid", 32'(bus_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
